mux_nto1_pipe: RTL and testbench
================================

Name: mux_nto1_pipe

Overview:
Parametrised N-to-1 data selector with a built-in pipeline register. It is the successor to the plain 2-to-1 select, for pipeline-stage boundaries in the processor datapath, e.g. ALU-source and forwarding selects feeding the next stage register. It adds stall (hold), flush (bubble insertion), valid tracking and out-of-range select detection. Output is registered: 1-cycle latency.

Parameters:
size, 32, data width in bits of each input and of data_o (must be >= 1)
num, 4, number of data inputs (2..16)
sel_w, 2, select width in bits; must satisfy 2^sel_w >= num
flush_val, 0, value loaded into data_o on reset and flush (size bits)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
data_i  input  size*num  flattened inputs; input k occupies bits [k*size +: size]
select_i  input  sel_w  binary index of the input to capture
valid_i  input  1  incoming data is a real instruction/operand, not a bubble
stall_i  input  1  hold stage contents
flush_i  input  1  replace stage contents with a bubble
clr_err_i  input  1  clear sticky error flag
data_o  output  size  registered selected data
valid_o  output  1  registered valid
sel_err_o  output  1  sticky flag: an out-of-range select was captured with valid_i=1

Behaviour:
- Reset (rst_i=1 at clock edge): data_o=flush_val, valid_o=0, sel_err_o=0. Reset overrides all other inputs.
- Per-edge priority for data_o/valid_o: rst_i > flush_i > stall_i > load.
- Flush: data_o=flush_val, valid_o=0. Flush wins over a simultaneous stall.
- Stall (flush_i=0): data_o and valid_o hold their values. select_i and data_i are ignored.
- Load (no rst/flush/stall):
  - If select_i < num: data_o = input[select_i] and valid_o = valid_i.
  - If select_i >= num: data_o = flush_val and valid_o = 0.
- Latency: data and valid appear on the outputs one clock after the load edge. There is no combinational path from any input to any output.
- sel_err_o:
  - Set on a load edge where select_i >= num and valid_i=1.
  - Not set on stall, flush or reset edges, nor when valid_i=0.
  - Cleared by clr_err_i=1 at an edge; otherwise holds.
  - If set and clear occur on the same edge, set wins and the flag stays 1.
  - Reset clears it.
- An out-of-range select with valid_i=0 loads a bubble silently.
- When num is a power of two, the out-of-range case is unreachable. The logic must still synthesise cleanly and sel_err_o must stay 0.
- Reset asserted mid-stall or mid-flush: the reset values appear after that edge. The cycle after rst_i falls behaves as a normal load.
- No X propagation: the unselected inputs must not affect data_o.

Test Plan:
- Reset, then size=32, num=4, data_i={D3=0x33,D2=0x22,D1=0x11,D0=0x00}, select_i=2, valid_i=1, one edge -> data_o=0x22 and valid_o=1 after that edge; before it, data_o=0 and valid_o=0.
- Cycle selects 0,1,2,3 on consecutive edges with valid_i alternating 1,0 -> data_o follows 0x00,0x11,0x22,0x33 one cycle late; valid_o follows 1,0,1,0 one cycle late.
- Load 0x11, then hold stall_i=1 for 3 edges while select_i=3 -> data_o stays 0x11 and valid_o stays 1 for those edges. Release stall -> data_o=0x33.
- flush_i=1 and stall_i=1 on the same edge while data_o=0x33 -> data_o=flush_val (0) and valid_o=0.
- num=3, sel_w=2, select_i=3, valid_i=1 -> data_o=0, valid_o=0, sel_err_o=1.
  - Flag persists across subsequent normal loads.
  - clr_err_i=1 with select_i=3, valid_i=1 on the same edge -> flag stays 1.
  - clr_err_i=1 with select_i=0 -> flag drops to 0.
- Assert rst_i for one edge during a stall with data_o=0x22 -> data_o=0, valid_o=0, sel_err_o=0. The next edge with select_i=1, valid_i=1 -> data_o=0x11.

Source files
------------

// File: rtl/mux_nto1_pipe.sv
// N-to-1 data selector with a single registered pipeline stage.
// Supports stall (hold), flush (bubble insertion) and valid tracking, and keeps
// a sticky flag for out-of-range selects that were captured with valid data.
module mux_nto1_pipe #(
    parameter int unsigned      size      = 32,
    parameter int unsigned      num       = 4,
    parameter int unsigned      sel_w     = 2,
    parameter logic [size-1:0]  flush_val = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [size*num-1:0] data_i,
    input  logic [sel_w-1:0]    select_i,
    input  logic                valid_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                clr_err_i,
    output logic [size-1:0]     data_o,
    output logic                valid_o,
    output logic                sel_err_o
);

    logic [size-1:0] sel_data;
    logic            in_range;
    logic            load;

    logic [size-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    // When num fills the select space every code is legal, so the range check
    // collapses to a constant and the error flag can never be set.
    if ((64'd1 << sel_w) > 64'(num)) begin : g_range_chk
        assign in_range = (32'(select_i) < num);
    end else begin : g_range_full
        assign in_range = 1'b1;
    end

    assign load = ~flush_i & ~stall_i;

    // Select one input by exact index match; unselected inputs never reach the
    // result, and an out-of-range code yields the bubble value.
    always_comb begin
        sel_data = flush_val;
        for (int k = 0; k < int'(num); k++) begin
            if (select_i == sel_w'(k)) begin
                sel_data = data_i[k*size +: size];
            end
        end
    end

    // Next-state for the stage contents: flush beats stall, stall beats load.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i) begin
            data_d  = flush_val;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            data_d  = sel_data;
            valid_d = in_range & valid_i;
        end
    end

    // Sticky error: a set on this edge outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (load && !in_range && valid_i) begin
            err_d = 1'b1;
        end else if (clr_err_i) begin
            err_d = 1'b0;
        end
    end

    // Stage register with synchronous reset overriding everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= flush_val;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign sel_err_o = err_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Scoreboard bench for mux_nto1_pipe: one instance with num=4 (power of two)
// and one with num=3 (out-of-range select reachable), sharing all stimulus.
module tb_mux_nto1_pipe;

    localparam logic [31:0] FV4 = 32'h0000_0000;
    localparam logic [31:0] FV3 = 32'hA5A5_5A5A;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic [127:0] data_i = '0;
    logic [1:0]   select_i = '0;
    logic         valid_i = 1'b0;
    logic         stall_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         clr_err_i = 1'b0;

    logic [31:0]  data4, data3;
    logic         valid4, valid3, err4, err3;

    always #5 clk = ~clk;

    mux_nto1_pipe #(.size(32), .num(4), .sel_w(2), .flush_val(FV4)) u_dut4 (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .select_i  (select_i),
        .valid_i   (valid_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .clr_err_i (clr_err_i),
        .data_o    (data4),
        .valid_o   (valid4),
        .sel_err_o (err4)
    );

    mux_nto1_pipe #(.size(32), .num(3), .sel_w(2), .flush_val(FV3)) u_dut3 (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .data_i    (data_i[95:0]),
        .select_i  (select_i),
        .valid_i   (valid_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .clr_err_i (clr_err_i),
        .data_o    (data3),
        .valid_o   (valid3),
        .sel_err_o (err3)
    );

    typedef struct packed {
        logic [31:0] d4;
        logic        v4;
        logic        e4;
        logic [31:0] d3;
        logic        v3;
        logic        e3;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference state: what each stage should hold after the pending edge.
    logic [31:0] words[4];
    logic [31:0] m_d[2];
    logic        m_v[2];
    logic        m_e[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural rules for one edge, applied to both configurations.
    task automatic model(input logic rst, input logic flush, input logic stall,
                         input logic clr, input logic vld, input logic [1:0] sel);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            int unsigned n  = (i == 0) ? 4 : 3;
            logic [31:0] fv = (i == 0) ? FV4 : FV3;
            if (rst) begin
                m_d[i] = fv;
                m_v[i] = 1'b0;
                m_e[i] = 1'b0;
            end else begin
                if (flush) begin
                    m_d[i] = fv;
                    m_v[i] = 1'b0;
                end else if (!stall) begin
                    if (32'(sel) < n) begin
                        m_d[i] = words[sel];
                        m_v[i] = vld;
                    end else begin
                        m_d[i] = fv;
                        m_v[i] = 1'b0;
                    end
                end
                if (!flush && !stall && 32'(sel) >= n && vld) m_e[i] = 1'b1;
                else if (clr) m_e[i] = 1'b0;
            end
        end
        e.d4 = m_d[0]; e.v4 = m_v[0]; e.e4 = m_e[0];
        e.d3 = m_d[1]; e.v3 = m_v[1]; e.e3 = m_e[1];
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic flush, input logic stall,
                         input logic clr, input logic vld, input logic [1:0] sel);
        @(negedge clk);
        rst_i     = rst;
        flush_i   = flush;
        stall_i   = stall;
        clr_err_i = clr;
        valid_i   = vld;
        select_i  = sel;
        data_i    = {words[3], words[2], words[1], words[0]};
        model(rst, flush, stall, clr, vld, sel);
    endtask

    // Monitor: after every rising edge, compare outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("data4",  data4,          e.d4);
                check("valid4", 32'(valid4),    32'(e.v4));
                check("err4",   32'(err4),      32'(e.e4));
                check("data3",  data3,          e.d3);
                check("valid3", 32'(valid3),    32'(e.v3));
                check("err3",   32'(err3),      32'(e.e3));
            end
        end
    end

    initial begin
        words[0] = 32'h00; words[1] = 32'h11; words[2] = 32'h22; words[3] = 32'h33;

        // Reset, then a single load of input 2.
        drive(1, 0, 0, 0, 0, 2'd0);
        drive(0, 0, 0, 0, 1, 2'd2);
        // Walk selects with alternating valid.
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, (i % 2 == 0), 2'(i));
        // Load 0x11, stall three edges with select 3, then release.
        drive(0, 0, 0, 0, 1, 2'd1);
        repeat (3) drive(0, 0, 1, 0, 1, 2'd3);
        drive(0, 0, 0, 0, 1, 2'd3);
        // Flush and stall together.
        drive(0, 1, 1, 0, 1, 2'd3);
        // Out-of-range for num=3, persistence, clear collisions.
        drive(0, 0, 0, 0, 1, 2'd3);
        drive(0, 0, 0, 0, 1, 2'd0);
        drive(0, 0, 0, 0, 1, 2'd1);
        drive(0, 0, 0, 1, 1, 2'd3);
        drive(0, 0, 0, 1, 1, 2'd0);
        // Out-of-range with valid low: silent bubble.
        drive(0, 0, 0, 0, 0, 2'd3);
        // Reset during a stall, then a normal load.
        drive(0, 0, 0, 0, 1, 2'd2);
        drive(0, 0, 1, 0, 1, 2'd0);
        drive(1, 0, 1, 0, 1, 2'd3);
        drive(0, 0, 0, 0, 1, 2'd1);

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++) words[k] = $urandom();
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
